// File: rtl/flow_block_interleaver.sv
// Multi-flow block interleaver: per-flow FIFOs are drained to one shared output
// in atomic blocks of per-flow programmable length, rotating round-robin.
module flow_block_interleaver #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned FLUX      = 2,
   parameter int unsigned TAG_W     = 1,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned LEN_W     = 7,
   parameter int unsigned BLOCK_DEF = 15
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [TAG_W+LEN_W-1:0]  cfg_din_i,
   input  logic                    cfg_write_i,
   input  logic [TAG_W+DATA_W-1:0] in_din_i,
   input  logic                    in_write_i,
   output logic [FLUX-1:0]         in_full_o,
   output logic [TAG_W+DATA_W-1:0] out_din_o,
   output logic                    out_write_o,
   input  logic                    out_full_i,
   output logic                    err_ovf_o,
   output logic                    err_tag_o
);
   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned TAGX_W = TAG_W + 1;
   localparam logic [TAGX_W-1:0] FLUX_T   = TAGX_W'(FLUX);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic {SELECT, STREAM} state_t;

   state_t                  state_q, state_d;
   logic [TAG_W-1:0]        cur_q, cur_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic [LEN_W-1:0]        cnt_q, cnt_d;
   logic [LEN_W-1:0]        block_len_q [FLUX];
   logic [CNT_W-1:0]        count_q     [FLUX];
   logic [PTR_W-1:0]        wr_ptr_q    [FLUX];
   logic [PTR_W-1:0]        rd_ptr_q    [FLUX];
   logic [DATA_W-1:0]       mem_q       [FLUX][DEPTH];
   logic [TAG_W+DATA_W-1:0] out_din_q;
   logic                    out_write_q;
   logic                    err_ovf_q;
   logic                    err_tag_q;

   logic [TAG_W-1:0]  in_tag;
   logic [TAG_W-1:0]  cfg_tag;
   logic [DATA_W-1:0] in_data;
   logic [LEN_W-1:0]  cfg_len;
   logic              in_tag_ok;
   logic              cfg_tag_ok;
   logic              ovf_hit;
   logic [FLUX-1:0]   full;
   logic [FLUX-1:0]   eligible;
   logic [FLUX-1:0]   push;
   logic [FLUX-1:0]   pop_f;
   logic              pop;
   logic              hit;
   logic [CNT_W-1:0]  cur_count;
   logic [DATA_W-1:0] cur_data;

   // Input/config decode and per-flow status.
   always_comb begin
      in_tag     = in_din_i[DATA_W +: TAG_W];
      in_data    = in_din_i[DATA_W-1:0];
      cfg_tag    = cfg_din_i[LEN_W +: TAG_W];
      cfg_len    = cfg_din_i[LEN_W-1:0];
      in_tag_ok  = {1'b0, in_tag} < FLUX_T;
      cfg_tag_ok = {1'b0, cfg_tag} < FLUX_T;
      ovf_hit    = 1'b0;
      cur_count  = '0;
      cur_data   = '0;
      full       = '0;
      eligible   = '0;
      push       = '0;
      for (int unsigned f = 0; f < FLUX; f++) begin
         full[f]     = (count_q[f] == FULL_CNT);
         eligible[f] = (count_q[f] != '0) && (block_len_q[f] != '0);
         push[f]     = in_write_i && in_tag_ok && (in_tag == TAG_W'(f)) && !full[f];
         if (in_write_i && in_tag_ok && (in_tag == TAG_W'(f)) && full[f]) begin
            ovf_hit = 1'b1;
         end
         if (cur_q == TAG_W'(f)) begin
            cur_count = count_q[f];
            cur_data  = mem_q[f][rd_ptr_q[f]];
         end
      end
   end

   assign in_full_o = full;

   // Scheduler: round-robin selection, then an atomic block from the chosen flow.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      hit     = 1'b0;
      pop_f   = '0;
      case (state_q)
         SELECT: begin
            for (int unsigned i = 1; i <= FLUX; i++) begin
               for (int unsigned f = 0; f < FLUX; f++) begin
                  if (!hit && eligible[f] && (((32'(cur_q) + i) % FLUX) == f)) begin
                     hit   = 1'b1;
                     cur_d = TAG_W'(f);
                     len_d = block_len_q[f];
                  end
               end
            end
            if (hit) begin
               cnt_d   = '0;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if ((cur_count != '0) && !out_full_i) begin
               pop   = 1'b1;
               cnt_d = cnt_q + LEN_W'(1);
               if ((cnt_q + LEN_W'(1)) == len_q) begin
                  state_d = SELECT;
               end
            end
         end
         default: state_d = SELECT;
      endcase
      for (int unsigned f = 0; f < FLUX; f++) begin
         pop_f[f] = pop && (cur_q == TAG_W'(f));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= SELECT;
         cur_q       <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         out_din_q   <= '0;
         out_write_q <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_tag_q   <= 1'b0;
         for (int unsigned f = 0; f < FLUX; f++) begin
            block_len_q[f] <= LEN_W'(BLOCK_DEF);
            count_q[f]     <= '0;
            wr_ptr_q[f]    <= '0;
            rd_ptr_q[f]    <= '0;
         end
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         out_write_q <= pop;
         if (pop) begin
            out_din_q <= {cur_q, cur_data};
         end
         if (ovf_hit) begin
            err_ovf_q <= 1'b1;
         end
         if ((in_write_i && !in_tag_ok) || (cfg_write_i && !cfg_tag_ok)) begin
            err_tag_q <= 1'b1;
         end
         for (int unsigned f = 0; f < FLUX; f++) begin
            if (push[f]) begin
               wr_ptr_q[f] <= wr_ptr_q[f] + PTR_W'(1);
            end
            if (pop_f[f]) begin
               rd_ptr_q[f] <= rd_ptr_q[f] + PTR_W'(1);
            end
            count_q[f] <= count_q[f] + CNT_W'(push[f]) - CNT_W'(pop_f[f]);
            if (cfg_write_i && cfg_tag_ok && (cfg_tag == TAG_W'(f))) begin
               block_len_q[f] <= cfg_len;
            end
         end
      end
   end

   // Sample storage needs no reset; validity is tracked by the pointers.
   always_ff @(posedge clk_i) begin
      for (int unsigned f = 0; f < FLUX; f++) begin
         if (push[f]) begin
            mem_q[f][wr_ptr_q[f]] <= in_data;
         end
      end
   end

   assign out_din_o   = out_din_q;
   assign out_write_o = out_write_q;
   assign err_ovf_o   = err_ovf_q;
   assign err_tag_o   = err_tag_q;

endmodule

// File: tb/tb_flow_block_interleaver.sv
// Scoreboard bench for flow_block_interleaver: per-flow expected queues plus
// tag-run and output-timing checks over directed scenarios.
module tb_flow_block_interleaver;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned FLUX      = 2;
   localparam int unsigned TAG_W     = 2;
   localparam int unsigned DEPTH     = 16;
   localparam int unsigned LEN_W     = 7;
   localparam int unsigned BLOCK_DEF = 15;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [TAG_W+LEN_W-1:0]  cfg_din;
   logic                    cfg_write;
   logic [TAG_W+DATA_W-1:0] in_din;
   logic                    in_write;
   logic [FLUX-1:0]         in_full;
   logic [TAG_W+DATA_W-1:0] out_din;
   logic                    out_write;
   logic                    out_full;
   logic                    err_ovf;
   logic                    err_tag;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [DATA_W-1:0] exp_q0[$];
   logic [DATA_W-1:0] exp_q1[$];
   int                tag_log[$];
   int                out_cyc[$];
   int                er[$];

   logic [TAG_W-1:0]  mon_t;
   logic [DATA_W-1:0] mon_d;
   logic [DATA_W-1:0] mon_e;
   bit                mon_has;

   flow_block_interleaver #(
      .DATA_W(DATA_W), .FLUX(FLUX), .TAG_W(TAG_W), .DEPTH(DEPTH),
      .LEN_W(LEN_W), .BLOCK_DEF(BLOCK_DEF)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .cfg_din_i(cfg_din), .cfg_write_i(cfg_write),
      .in_din_i(in_din), .in_write_i(in_write), .in_full_o(in_full),
      .out_din_o(out_din), .out_write_o(out_write), .out_full_i(out_full),
      .err_ovf_o(err_ovf), .err_tag_o(err_tag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every output sample is matched against its flow's expected queue.
   always @(negedge clk) begin
      if (!rst && out_write) begin
         mon_t   = out_din[DATA_W +: TAG_W];
         mon_d   = out_din[DATA_W-1:0];
         mon_has = 1'b0;
         checks++;
         if (mon_t == 2'd0 && exp_q0.size() != 0) begin
            mon_e = exp_q0.pop_front(); mon_has = 1'b1;
         end else if (mon_t == 2'd1 && exp_q1.size() != 0) begin
            mon_e = exp_q1.pop_front(); mon_has = 1'b1;
         end
         if (!mon_has) begin
            errors++;
            $display("FAIL out_unexpected: got tag %0d data %0h, required no output", mon_t, mon_d);
         end else if (mon_d !== mon_e) begin
            errors++;
            $display("FAIL out_data: flow %0d got %0h required %0h", mon_t, mon_d, mon_e);
         end
         tag_log.push_back(32'(mon_t));
         out_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic wr(input int tag, input int d, input bit ok = 1'b1);
      in_din   = {TAG_W'(tag), DATA_W'(d)};
      in_write = 1'b1;
      if (ok) begin
         if (tag == 0) exp_q0.push_back(DATA_W'(d));
         else          exp_q1.push_back(DATA_W'(d));
      end
      @(negedge clk);
      in_write = 1'b0;
   endtask

   task automatic cfg(input int tag, input int len);
      cfg_din   = {TAG_W'(tag), LEN_W'(len)};
      cfg_write = 1'b1;
      @(negedge clk);
      cfg_write = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_write  = 1'b0;
      cfg_write = 1'b0;
      out_full  = 1'b0;
      @(posedge clk);
      exp_q0.delete(); exp_q1.delete(); tag_log.delete(); out_cyc.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Compresses the output tag log into runs coded as tag*10000+length.
   task automatic check_runs(input string name, input int exp[$]);
      int act[$];
      int ct, len, di;
      ct = -1; len = 0; di = -1;
      foreach (tag_log[i]) begin
         if (tag_log[i] == ct) len++;
         else begin
            if (len > 0) act.push_back(ct * 10000 + len);
            ct = tag_log[i]; len = 1;
         end
      end
      if (len > 0) act.push_back(ct * 10000 + len);
      for (int i = 0; i < act.size() && i < exp.size(); i++)
         if (di < 0 && act[i] != exp[i]) di = i;
      if (di < 0 && act.size() != exp.size()) di = (act.size() < exp.size()) ? act.size() : exp.size();
      checks++;
      if (di >= 0) begin
         errors++;
         $display("FAIL %s: got %0d runs (run %0d = %0d), required %0d runs (run %0d = %0d)",
                  name, act.size(), di, (di < act.size()) ? act[di] : -1,
                  exp.size(), di, (di < exp.size()) ? exp[di] : -1);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      int n0, n1, turn, pick, guard;
      rst = 1'b1; in_din = '0; in_write = 1'b0; cfg_din = '0; cfg_write = 1'b0; out_full = 1'b0;
      idle(2);
      do_reset();
      chk("rst_out_write", 32'(out_write), 0);
      chk("rst_out_din",   32'(out_din),   0);
      chk("rst_in_full",   32'(in_full),   0);
      chk("rst_err_ovf",   32'(err_ovf),   0);
      chk("rst_err_tag",   32'(err_tag),   0);

      // Two flows, lengths 15/39, feeder alternates between flows.
      cfg(1, 39);
      n0 = 0; n1 = 0; turn = 0; guard = 0;
      while ((n0 < 225 || n1 < 1521) && guard < 20000) begin
         pick = -1;
         if (turn == 0) begin
            if (n0 < 225 && !in_full[0]) pick = 0;
            else if (n1 < 1521 && !in_full[1]) pick = 1;
         end else begin
            if (n1 < 1521 && !in_full[1]) pick = 1;
            else if (n0 < 225 && !in_full[0]) pick = 0;
         end
         turn ^= 1;
         if (pick == 0) begin wr(0, n0); n0++; end
         else if (pick == 1) begin wr(1, n1 * 3 + 1); n1++; end
         else idle(1);
         guard++;
      end
      for (int w = 0; w < 5000 && (exp_q0.size() != 0 || exp_q1.size() != 0); w++) idle(1);
      chk("p1_drain", exp_q0.size() + exp_q1.size(), 0);
      er.delete();
      for (int i = 0; i < 14; i++) begin er.push_back(15); er.push_back(10039); end
      er.push_back(15); er.push_back(10975);
      check_runs("p1_runs", er);
      chk("p1_err_ovf", 32'(err_ovf), 0);
      chk("p1_err_tag", 32'(err_tag), 0);

      // Latency from an idle design.
      do_reset();
      wr(0, 'hA5);
      @(posedge clk); #1;
      chk("lat_k1_write", 32'(out_write), 0);
      @(posedge clk); #1;
      chk("lat_k2_write", 32'(out_write), 1);
      chk("lat_k2_din",   32'(out_din), 'h0A5);
      @(negedge clk);

      // One idle SELECT cycle between back-to-back blocks of the same flow.
      do_reset();
      cfg(0, 3);
      for (int i = 0; i < 6; i++) wr(0, 'h10 + i);
      idle(6);
      chk("bubble_count", out_cyc.size(), 6);
      if (out_cyc.size() == 6) begin
         int pat;
         pat = 0;
         for (int i = 0; i < 6; i++) pat |= (out_cyc[i] - out_cyc[0]) << (4 * i);
         chk("bubble_pattern", pat, 'h654210);
      end

      // Backpressure mid-block, FIFO full and overflow drop.
      do_reset();
      cfg(0, 20);
      for (int i = 0; i < 4; i++) wr(0, 'h40 + i);
      idle(6);
      out_full = 1'b1;
      out_cyc.delete();
      for (int i = 0; i < 15; i++) wr(0, 'h50 + i);
      chk("bp_full_at_15", 32'(in_full[0]), 0);
      wr(0, 'h5F);
      chk("bp_full_at_16", 32'(in_full[0]), 1);
      chk("bp_ovf_before", 32'(err_ovf), 0);
      wr(0, 'hEE, 1'b0);
      chk("bp_ovf_after", 32'(err_ovf), 1);
      idle(3);
      chk("bp_no_output", out_cyc.size(), 0);
      out_full = 1'b0;
      idle(30);
      chk("bp_resumed", out_cyc.size(), 16);
      chk("bp_no_loss", exp_q0.size(), 0);

      // Block atomicity: starved flow-0 block holds off flow 1.
      do_reset();
      cfg(0, 8);
      for (int i = 0; i < 3; i++) wr(0, 'h30 + i);
      for (int i = 0; i < 5; i++) wr(1, 'h70 + i);
      idle(10);
      chk("atom_starved", tag_log.size(), 3);
      for (int i = 3; i < 8; i++) wr(0, 'h30 + i);
      idle(20);
      er.delete(); er.push_back(8); er.push_back(10005);
      check_runs("atom_runs", er);
      chk("atom_drain", exp_q0.size() + exp_q1.size(), 0);

      // Config: disable/enable flow 1, mid-block length change on flow 0, bad tag.
      do_reset();
      cfg(1, 0);
      for (int i = 0; i < 4; i++) wr(1, 'h80 + i);
      idle(10);
      chk("cfg_disabled", tag_log.size(), 0);
      cfg(1, 4);
      idle(8);
      for (int i = 4; i < 8; i++) wr(1, 'h80 + i);
      idle(8);
      cfg(0, 6);
      for (int i = 0; i < 3; i++) wr(0, 'h90 + i);
      idle(6);
      cfg(0, 2);
      for (int i = 8; i < 12; i++) wr(1, 'h80 + i);
      for (int i = 3; i < 8; i++) wr(0, 'h90 + i);
      idle(20);
      er.delete(); er.push_back(10008); er.push_back(6); er.push_back(10004); er.push_back(2);
      check_runs("cfg_runs", er);
      chk("cfg_drain", exp_q0.size() + exp_q1.size(), 0);
      chk("cfg_tag_before", 32'(err_tag), 0);
      cfg(3, 5);
      chk("cfg_tag_after", 32'(err_tag), 1);

      // Reset in the middle of a flow-1 block with both error flags set.
      for (int i = 0; i < 3; i++) wr(1, 'hA0 + i);
      idle(5);
      out_full = 1'b1;
      for (int i = 0; i < 16; i++) wr(0, 'hB0 + i);
      wr(0, 'hCC, 1'b0);
      chk("mid_ovf_set", 32'(err_ovf), 1);
      do_reset();
      chk("mid_out_write", 32'(out_write), 0);
      chk("mid_in_full",   32'(in_full),   0);
      chk("mid_err_ovf",   32'(err_ovf),   0);
      chk("mid_err_tag",   32'(err_tag),   0);
      for (int i = 0; i < 16; i++) wr(0, 'hD0 + i);
      for (int i = 0; i < 2; i++) wr(1, 'hE0 + i);
      idle(30);
      er.delete(); er.push_back(15); er.push_back(10002);
      check_runs("mid_runs", er);
      chk("mid_flow0_held", exp_q0.size(), 1);
      chk("mid_flow1_done", exp_q1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
